// File: rtl/lpc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lpc_pkg                                                    |
// | Description : Shared FSM encoding, default addresses and status layout   |
// |               for the LPC POST-code capture stage.                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package lpc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_WAIT = 3'd1,
      ST_WR_ACK  = 3'd2,
      ST_RD_WAIT = 3'd3,
      ST_RD_ACK  = 3'd4
   } lpc_state_t;

   localparam logic [15:0] c_post_addr_default   = 16'h0080;
   localparam logic [15:0] c_status_addr_default = 16'h0081;
   localparam int          OVF_BIT               = 7;

   // Status byte: sticky overflow in the MSB, low five occupancy bits at the bottom.
   function automatic logic [7:0] status_byte(input logic ovf, input logic [4:0] cnt);
      logic [7:0] b;
      b          = 8'h00;
      b[OVF_BIT] = ovf;
      b[4:0]     = cnt;
      return b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lpc_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lpc_sync_fifo                                              |
// | Description : Synchronous circular FIFO with registered count/flags and  |
// |               a combinational head read.                                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module lpc_sync_fifo #(
   parameter int AW = 4,
   parameter int DW = 8
) (
   input  logic          clk_i,
   input  logic          LRESET,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   localparam int          c_depth    = 2**AW;
   localparam logic [AW:0] c_one      = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0] c_full_cnt = {1'b1, {AW{1'b0}}};

   logic [DW-1:0] r_mem [c_depth];
   logic [AW:0]   r_wptr;
   logic [AW:0]   r_rptr;
   logic [AW:0]   r_count;
   logic          r_full;
   logic          r_empty;
   logic          w_push_en;
   logic          w_pop_en;
   logic [AW:0]   w_count_nxt;

   // A pop never frees space for a push on the same edge: full always drops.
   assign w_push_en = push && !r_full;
   assign w_pop_en  = pop && !r_empty;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push_en, w_pop_en})
         2'b10:   w_count_nxt = r_count + c_one;
         2'b01:   w_count_nxt = r_count - c_one;
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge clk_i or negedge LRESET) begin
      if (!LRESET) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         if (w_push_en) r_wptr <= r_wptr + c_one;
         if (w_pop_en)  r_rptr <= r_rptr + c_one;
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == c_full_cnt);
         r_empty <= (w_count_nxt == '0);
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push_en) r_mem[r_wptr[AW-1:0]] <= din;
   end

   assign dout  = r_mem[r_rptr[AW-1:0]];
   assign full  = r_full;
   assign empty = r_empty;
   assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/lpc_post_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lpc_post_capture                                           |
// | Description : Terminates lpc_periph read/write handshakes, captures POST |
// |               codes into a FIFO and serves last-code/status reads.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module lpc_post_capture
   import lpc_pkg::*;
#(
   parameter logic [15:0] POST_ADDR   = c_post_addr_default,
   parameter logic [15:0] STATUS_ADDR = c_status_addr_default,
   parameter int          FIFO_AW     = 4,
   parameter int          ACK_DELAY   = 0
) (
   input  logic               clk_i,
   input  logic               LRESET,
   input  logic [15:0]        lpc_addr_i,
   inout  wire  [7:0]         lpc_data_io,
   input  logic               lpc_data_wr,
   output logic               lpc_wr_done,
   input  logic               lpc_data_req,
   output logic               lpc_data_rd,
   output logic [7:0]         code_o,
   output logic               code_valid_o,
   input  logic               code_ready_i,
   output logic [FIFO_AW:0]   fifo_count_o,
   output logic               overflow_o
);

   localparam logic [3:0] c_ack_delay = 4'(ACK_DELAY);

   lpc_state_t   r_state;
   lpc_state_t   w_state_nxt;
   logic [3:0]   r_dly_cnt;
   logic [3:0]   w_dly_nxt;
   logic         r_wr_done;
   logic         r_data_rd;
   logic         w_wr_done_nxt;
   logic         w_data_rd_nxt;
   logic         w_cap_wr;
   logic         w_cap_rd;
   logic         w_wr_fire;
   logic         w_rd_fire;
   logic         w_rd_exit;
   logic         w_dly_done;

   logic [15:0]  r_addr;
   logic [7:0]   r_wdata;
   logic [7:0]   r_rdata;
   logic [7:0]   r_last_code;
   logic         r_overflow;
   logic         w_push;
   logic         w_ovf_set;
   logic         w_ovf_clr;
   logic [7:0]   w_rd_mux;
   logic         w_fifo_full;
   logic         w_fifo_empty;
   logic [FIFO_AW:0] w_count;

   assign w_dly_done = (r_dly_cnt == c_ack_delay);

   always_ff @(posedge clk_i or negedge LRESET) begin
      if (!LRESET) begin
         r_state   <= ST_IDLE;
         r_dly_cnt <= 4'd0;
         r_wr_done <= 1'b0;
         r_data_rd <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_dly_cnt <= w_dly_nxt;
         r_wr_done <= w_wr_done_nxt;
         r_data_rd <= w_data_rd_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_dly_nxt     = r_dly_cnt;
      w_wr_done_nxt = 1'b0;
      w_data_rd_nxt = 1'b0;
      w_cap_wr      = 1'b0;
      w_cap_rd      = 1'b0;
      w_wr_fire     = 1'b0;
      w_rd_fire     = 1'b0;
      w_rd_exit     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_dly_nxt = 4'd0;
            // Write has priority; a pending read is picked up after it completes.
            if (lpc_data_wr) begin
               w_cap_wr    = 1'b1;
               w_state_nxt = ST_WR_WAIT;
            end else if (lpc_data_req) begin
               w_cap_rd    = 1'b1;
               w_state_nxt = ST_RD_WAIT;
            end
         end
         ST_WR_WAIT: begin
            if (w_dly_done) begin
               w_wr_fire     = 1'b1;
               w_wr_done_nxt = 1'b1;
               w_dly_nxt     = 4'd0;
               w_state_nxt   = ST_WR_ACK;
            end else begin
               w_dly_nxt = r_dly_cnt + 4'd1;
            end
         end
         ST_WR_ACK: begin
            w_wr_done_nxt = lpc_data_wr;
            if (!lpc_data_wr) w_state_nxt = ST_IDLE;
         end
         ST_RD_WAIT: begin
            if (w_dly_done) begin
               w_rd_fire     = 1'b1;
               w_data_rd_nxt = 1'b1;
               w_dly_nxt     = 4'd0;
               w_state_nxt   = ST_RD_ACK;
            end else begin
               w_dly_nxt = r_dly_cnt + 4'd1;
            end
         end
         ST_RD_ACK: begin
            w_data_rd_nxt = lpc_data_req;
            if (!lpc_data_req) begin
               w_rd_exit   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_push    = w_wr_fire && (r_addr == POST_ADDR);
   assign w_ovf_set = w_push && w_fifo_full;
   assign w_ovf_clr = w_rd_exit && (r_addr == STATUS_ADDR);

   always_comb begin
      w_rd_mux = 8'hFF;
      if (r_addr == POST_ADDR)
         w_rd_mux = r_last_code;
      else if (r_addr == STATUS_ADDR)
         w_rd_mux = status_byte(r_overflow, 5'(w_count));
   end

   always_ff @(posedge clk_i or negedge LRESET) begin
      if (!LRESET) begin
         r_addr      <= 16'h0000;
         r_wdata     <= 8'h00;
         r_rdata     <= 8'h00;
         r_last_code <= 8'hFF;
         r_overflow  <= 1'b0;
      end else begin
         if (w_cap_wr) begin
            r_addr  <= lpc_addr_i;
            r_wdata <= lpc_data_io;
         end else if (w_cap_rd) begin
            r_addr <= lpc_addr_i;
         end
         if (w_push)    r_last_code <= r_wdata;
         if (w_rd_fire) r_rdata     <= w_rd_mux;
         if (w_ovf_set)      r_overflow <= 1'b1;
         else if (w_ovf_clr) r_overflow <= 1'b0;
      end
   end

   lpc_sync_fifo #(
      .AW (FIFO_AW),
      .DW (8)
   ) u_fifo (
      .clk_i (clk_i),
      .LRESET(LRESET),
      .push  (w_push),
      .pop   (code_ready_i),
      .din   (r_wdata),
      .dout  (code_o),
      .full  (w_fifo_full),
      .empty (w_fifo_empty),
      .count (w_count)
   );

   assign lpc_data_io  = r_data_rd ? r_rdata : 8'hzz;
   assign lpc_wr_done  = r_wr_done;
   assign lpc_data_rd  = r_data_rd;
   assign code_valid_o = !w_fifo_empty;
   assign fifo_count_o = w_count;
   assign overflow_o   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_lpc_post_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_lpc_post_capture                                        |
// | Description : Directed + random bench for lpc_post_capture, two         |
// |               instances (ACK_DELAY 0 and 10) against a queue model.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_lpc_post_capture;

   logic        clk_i = 1'b0;
   logic        LRESET;
   logic [15:0] addr    [2];
   logic        wr      [2];
   logic        req     [2];
   logic        rdy     [2];
   logic        drv_en  [2];
   logic [7:0]  drv     [2];
   logic        wr_done [2];
   logic        data_rd [2];
   logic        cvalid  [2];
   logic        ovf     [2];
   logic [7:0]  code    [2];
   logic [4:0]  cnt     [2];
   wire  [7:0]  dio0;
   wire  [7:0]  dio1;

   assign dio0 = drv_en[0] ? drv[0] : 8'hzz;
   assign dio1 = drv_en[1] ? drv[1] : 8'hzz;

   always #5 clk_i = ~clk_i;

   lpc_post_capture #(.ACK_DELAY(0)) u_dut0 (
      .clk_i(clk_i), .LRESET(LRESET), .lpc_addr_i(addr[0]), .lpc_data_io(dio0),
      .lpc_data_wr(wr[0]), .lpc_wr_done(wr_done[0]), .lpc_data_req(req[0]),
      .lpc_data_rd(data_rd[0]), .code_o(code[0]), .code_valid_o(cvalid[0]),
      .code_ready_i(rdy[0]), .fifo_count_o(cnt[0]), .overflow_o(ovf[0]));

   lpc_post_capture #(.ACK_DELAY(10)) u_dut1 (
      .clk_i(clk_i), .LRESET(LRESET), .lpc_addr_i(addr[1]), .lpc_data_io(dio1),
      .lpc_data_wr(wr[1]), .lpc_wr_done(wr_done[1]), .lpc_data_req(req[1]),
      .lpc_data_rd(data_rd[1]), .code_o(code[1]), .code_valid_o(cvalid[1]),
      .code_ready_i(rdy[1]), .fifo_count_o(cnt[1]), .overflow_o(ovf[1]));

   // Reference model: FIFO contents as a plain list, head at index 0.
   logic [7:0] mbuf  [2][16];
   int         msize [2];
   logic [7:0] mlast [2];
   logic       movf  [2];

   int passed = 0;
   int total  = 0;
   int fails  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h (failure #%0d)", tag, obs, exp, fails);
      end
   endtask

   function automatic int dly(input int k);
      return (k == 1) ? 10 : 0;
   endfunction

   function automatic logic [7:0] get_dio(input int k);
      return (k == 1) ? dio1 : dio0;
   endfunction

   function automatic logic get_sig(input int k, input int sel);
      return (sel == 0) ? wr_done[k] : data_rd[k];
   endfunction

   task automatic m_reset();
      for (int k = 0; k < 2; k++) begin
         msize[k] = 0;
         mlast[k] = 8'hFF;
         movf[k]  = 1'b0;
      end
   endtask

   task automatic m_write(input int k, input logic [15:0] a, input logic [7:0] d);
      if (a == 16'h0080) begin
         mlast[k] = d;
         if (msize[k] < 16) begin
            mbuf[k][msize[k]] = d;
            msize[k]++;
         end else begin
            movf[k] = 1'b1;
         end
      end
   endtask

   task automatic m_pop(input int k);
      if (msize[k] > 0) begin
         for (int i = 1; i < 16; i++) mbuf[k][i-1] = mbuf[k][i];
         msize[k]--;
      end
   endtask

   function automatic logic [7:0] m_read(input int k, input logic [15:0] a);
      if (a == 16'h0080) return mlast[k];
      if (a == 16'h0081) return 8'((movf[k] ? 128 : 0) + msize[k]);
      return 8'hFF;
   endfunction

   task automatic check_state(input int k, input string tag);
      chk($sformatf("%s count%0d", tag, k), cnt[k], msize[k]);
      chk($sformatf("%s valid%0d", tag, k), cvalid[k], (msize[k] > 0));
      chk($sformatf("%s ovf%0d", tag, k), ovf[k], movf[k]);
      if (msize[k] > 0) chk($sformatf("%s head%0d", tag, k), code[k], mbuf[k][0]);
   endtask

   // Released bus: a probe driven by the bench must read back unchanged.
   task automatic bus_free(input int k, input string tag);
      drv[k] = 8'h00; drv_en[k] = 1'b1;
      #1;
      chk($sformatf("%s bus_free%0d", tag, k), get_dio(k), 8'h00);
      drv_en[k] = 1'b0;
   endtask

   task automatic wait_hi(input int k, input int sel, output int n);
      n = 0;
      while (!get_sig(k, sel) && n < 64) begin
         @(posedge clk_i); #1; n++;
      end
      chk($sformatf("wait_ack%0d sel%0d", k, sel), get_sig(k, sel), 1'b1);
   endtask

   task automatic lpc_write(input int k, input logic [15:0] a, input logic [7:0] d);
      int n;
      addr[k] = a; drv[k] = d; drv_en[k] = 1'b1; wr[k] = 1'b1;
      wait_hi(k, 0, n);
      chk($sformatf("wr_latency%0d", k), n - 1, dly(k) + 1);
      m_write(k, a, d);
      wr[k] = 1'b0; drv_en[k] = 1'b0;
      @(posedge clk_i); #1;
      chk($sformatf("wr_done_drop%0d", k), wr_done[k], 1'b0);
      check_state(k, "after_wr");
   endtask

   task automatic lpc_read(input int k, input logic [15:0] a, output logic [7:0] got);
      int n;
      logic [7:0] exp;
      exp = m_read(k, a);
      addr[k] = a; req[k] = 1'b1;
      wait_hi(k, 1, n);
      chk($sformatf("rd_latency%0d", k), n - 1, dly(k) + 1);
      got = get_dio(k);
      chk($sformatf("rd_data%0d a=%h", k, a), got, exp);
      req[k] = 1'b0;
      @(posedge clk_i); #1;
      if (a == 16'h0081) movf[k] = 1'b0;
      chk($sformatf("rd_drop%0d", k), data_rd[k], 1'b0);
      bus_free(k, "after_rd");
      check_state(k, "after_rd");
   endtask

   task automatic pop_n(input int k, input int n);
      for (int i = 0; i < n; i++) begin
         rdy[k] = 1'b1;
         chk($sformatf("pop_valid%0d", k), cvalid[k], (msize[k] > 0));
         if (msize[k] > 0) chk($sformatf("pop_code%0d", k), code[k], mbuf[k][0]);
         @(posedge clk_i); #1;
         m_pop(k);
      end
      rdy[k] = 1'b0;
      check_state(k, "after_pop");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  got;
      logic [15:0] ra;
      int          n;
      int          op;

      LRESET = 1'b0;
      for (int k = 0; k < 2; k++) begin
         addr[k] = 16'h0; wr[k] = 1'b0; req[k] = 1'b0; rdy[k] = 1'b0;
         drv_en[k] = 1'b0; drv[k] = 8'h00;
      end
      m_reset();
      repeat (3) @(posedge clk_i);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("rst_wr_done%0d", k), wr_done[k], 1'b0);
         chk($sformatf("rst_data_rd%0d", k), data_rd[k], 1'b0);
         check_state(k, "rst");
         bus_free(k, "rst");
      end
      LRESET = 1'b1;
      @(posedge clk_i); #1;

      // Basic POST write and readback of reset last_code on the other instance.
      lpc_write(0, 16'h0080, 8'h5A);
      chk("first_code", code[0], 8'h5A);
      lpc_read(1, 16'h0080, got);
      chk("last_code_reset", got, 8'hFF);

      // Delayed instance: non-POST write leaves FIFO and last_code alone.
      lpc_write(1, 16'h0080, 8'h5A);
      lpc_write(1, 16'h9696, 8'hA5);
      lpc_read(1, 16'h0080, got);
      chk("last_code_kept", got, 8'h5A);
      pop_n(1, 1);

      // Write and read requested together: write first, then the read sees it.
      addr[0] = 16'h0080; drv[0] = 8'h77; drv_en[0] = 1'b1; wr[0] = 1'b1; req[0] = 1'b1;
      wait_hi(0, 0, n);
      m_write(0, 16'h0080, 8'h77);
      chk("both_no_rd_yet", data_rd[0], 1'b0);
      wr[0] = 1'b0; drv_en[0] = 1'b0;
      wait_hi(0, 1, n);
      chk("both_rd_data", get_dio(0), 8'h77);
      req[0] = 1'b0;
      @(posedge clk_i); #1;
      bus_free(0, "both");
      check_state(0, "both");
      pop_n(0, 2);

      // Overflow: 17 codes with no consumer.
      for (int i = 0; i < 17; i++) lpc_write(0, 16'h0080, 8'(i));
      chk("ovf_count", cnt[0], 5'd16);
      chk("ovf_flag", ovf[0], 1'b1);
      lpc_read(0, 16'h0081, got);
      chk("status_ovf", got, 8'h90);
      lpc_read(0, 16'h0081, got);
      chk("status_clr", got, 8'h10);
      lpc_read(0, 16'h0080, got);
      chk("last_is_dropped", got, 8'h10);

      // Drain back-to-back: one code per cycle in order.
      pop_n(0, 16);
      chk("drain_empty", cvalid[0], 1'b0);
      pop_n(0, 2);

      // Push and pop on the same edge at count 3.
      for (int i = 0; i < 3; i++) lpc_write(0, 16'h0080, 8'hC0 + 8'(i));
      addr[0] = 16'h0080; drv[0] = 8'hD7; drv_en[0] = 1'b1; wr[0] = 1'b1;
      @(posedge clk_i); #1;
      rdy[0] = 1'b1;
      @(posedge clk_i); #1;
      rdy[0] = 1'b0;
      m_pop(0);
      m_write(0, 16'h0080, 8'hD7);
      chk("pp_wr_done", wr_done[0], 1'b1);
      chk("pp_count", cnt[0], 5'd3);
      wr[0] = 1'b0; drv_en[0] = 1'b0;
      @(posedge clk_i); #1;
      check_state(0, "pp");
      pop_n(0, 3);

      // Reset in the middle of a delayed write aborts it without a push.
      lpc_write(1, 16'h0080, 8'h11);
      addr[1] = 16'h0080; drv[1] = 8'h22; drv_en[1] = 1'b1; wr[1] = 1'b1;
      repeat (4) @(posedge clk_i);
      #1;
      LRESET = 1'b0;
      #2;
      wr[1] = 1'b0; drv_en[1] = 1'b0;
      m_reset();
      chk("midrst_wr_done", wr_done[1], 1'b0);
      chk("midrst_count", cnt[1], 5'd0);
      check_state(0, "midrst");
      bus_free(1, "midrst");
      @(posedge clk_i); #1;
      LRESET = 1'b1;
      @(posedge clk_i); #1;
      lpc_write(1, 16'h0080, 8'h3C);
      lpc_read(1, 16'h0080, got);

      // Random mixed traffic on both instances.
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 30; i++) begin
            op = int'($urandom_range(0, 6));
            ra = 16'($urandom_range(0, 65535));
            case (op)
               0, 1: lpc_write(k, 16'h0080, 8'($urandom_range(0, 255)));
               2: lpc_write(k, (ra == 16'h0080) ? 16'h1234 : ra, 8'($urandom_range(0, 255)));
               3: lpc_read(k, 16'h0080, got);
               4: lpc_read(k, 16'h0081, got);
               5: lpc_read(k, (ra == 16'h0080 || ra == 16'h0081) ? 16'h4321 : ra, got);
               default: pop_n(k, int'($urandom_range(0, 3)));
            endcase
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
